latch_q_sampler: RTL
====================

# latch_q_sampler

Synchronous sampler stage that sits directly downstream of the design's 2-bit level-sensitive latch with asynchronous reset, and consumes the latch output Q. The latch output can change at any time, and its reset is asynchronous, so this block:
- brings Q into the CLK domain through a two-flop synchronizer;
- qualifies each new value by requiring it to be stable for a programmable number of cycles;
- reports each accepted change through a VALID/ACK handshake;
- keeps a saturating change counter and a sticky overrun flag.

## Interface
Parameters:
- WIDTH, 2, width of the sampled latch output.
- STABLE_CYCLES, 3, consecutive CLK cycles a synchronized value must hold before it is accepted. Legal range is 2 to 15.
- CNT_WIDTH, 8, width of the change counter.

Ports:
- CLK  input  1  single clock; all state updates on its rising edge.
- SRST  input  1  reset, synchronous and active-high; overrides every other input.
- Q_IN  input  WIDTH  latch output Q; asynchronous to CLK.
- ACK  input  1  consumer acknowledge for the current report.
- DATA_OUT  output  WIDTH  last accepted value; held constant outside acceptance edges.
- VALID  output  1  a report is pending on DATA_OUT.
- CHG_CNT  output  CNT_WIDTH  number of accepted changes; saturates at 2^CNT_WIDTH-1.
- OVERRUN  output  1  sticky flag: the input changed while a report was pending.

## Operation
- **Synchronizer:** S1 <= Q_IN, then S2 <= S1. Only S2 is used downstream.
- **Internal registers:** CAND (candidate value, WIDTH bits) and STAB (stability counter, 4 bits).
- **Reset:** SRST high at an edge forces the following. This applies mid-operation in any state, and takes priority over a coincident ACK.
  - S1, S2, CAND, STAB = 0
  - state = IDLE
  - DATA_OUT = 0, VALID = 0, CHG_CNT = 0, OVERRUN = 0
- **IDLE:**
  - If S2 != DATA_OUT: CAND <= S2, STAB <= 1, go to SETTLE.
  - Otherwise stay in IDLE.
- **SETTLE:** conditions are evaluated in this order on each edge.
  - If S2 == DATA_OUT: the change was a glitch and is rejected. Go to IDLE; DATA_OUT and CHG_CNT are unchanged.
  - Else if S2 != CAND: CAND <= S2, STAB <= 1, stay in SETTLE (restart qualification).
  - Else if STAB == STABLE_CYCLES-1: accept. DATA_OUT <= CAND, VALID <= 1, CHG_CNT <= CHG_CNT+1 (saturating), go to REPORT.
  - Else: STAB <= STAB+1.
- **REPORT:**
  - If ACK is high: VALID <= 0, go to IDLE.
  - If ACK is low: VALID stays 1 and DATA_OUT is frozen. If S2 != DATA_OUT, OVERRUN <= 1.
  - After returning to IDLE, a pending difference between S2 and DATA_OUT starts a new qualification normally.
- **ACK outside REPORT:** ignored, including ACK on the acceptance edge itself.
- **OVERRUN:** cleared only by SRST.
- **CHG_CNT:** at 2^CNT_WIDTH-1 it holds; acceptance still completes and VALID still asserts.

## Timing
- Let e1 be the first rising edge that samples a new stable Q_IN value into S1.
  - e2: the value reaches S2.
  - e3: IDLE detects the difference and moves to SETTLE.
  - VALID and the new DATA_OUT are visible after edge e(STABLE_CYCLES+2). This is 5 edges at the default.
- CHG_CNT updates on the same edge that VALID rises.
- VALID falls after the first edge in REPORT at which ACK is sampled high.
  - Minimum report length is 1 cycle: ACK held high continuously gives VALID high for exactly 1 cycle.
- Minimum spacing between two accepted changes is STABLE_CYCLES+1 edges. This assumes ACK is returned immediately and the second value is already present in S2.
- A glitch on Q_IN shorter than STABLE_CYCLES-1 cycles at S2, which then returns to DATA_OUT, produces no report and no count.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset:** SRST high for 2 cycles with Q_IN=2'b11 -> DATA_OUT=0, VALID=0, CHG_CNT=0, OVERRUN=0 after the first reset edge.
- **Single change, latency:** after reset, drive Q_IN 2'b00->2'b01 before edge e1, ACK tied low -> VALID=1 and DATA_OUT=2'b01 after e5; CHG_CNT=1. Assert ACK for one cycle -> VALID=0 on the next edge.
- **Glitch reject and restart:**
  - Q_IN=2'b10 for 2 cycles, then back to 2'b00 -> no VALID, CHG_CNT unchanged.
  - Q_IN 2'b10 for 2 cycles then 2'b11 held -> qualification restarts; DATA_OUT=2'b11 accepted 3 edges after 2'b11 first reaches S2.
- **Overrun and handshake hold:** accept 2'b01, keep ACK low, change Q_IN to 2'b10 -> DATA_OUT stays 2'b01, VALID stays 1, OVERRUN=1. Then ACK -> IDLE, 2'b10 accepted with normal latency, CHG_CNT=2, OVERRUN stays 1.
- **Saturation:** CNT_WIDTH=2, drive 5 accepted changes cycling through 00/01/10/11/00 with immediate ACK -> CHG_CNT reads 1,2,3,3,3; VALID pulses 5 times.
- **Reset mid-operation:** SRST asserted in SETTLE, and separately in REPORT together with ACK high -> all outputs 0 and state IDLE after that edge; no stale report afterwards unless Q_IN differs from 0.

Source files
------------

// File: rtl/latch_q_sampler.sv
// latch_q_sampler
// Synchronous sampler for the asynchronous output Q of an upstream 2-bit latch.
// Q is brought into the CLK domain through two flops. A new value is accepted only
// after it has been stable for STABLE_CYCLES cycles. Each accepted value is reported
// through a VALID/ACK handshake, and the block keeps a saturating change counter.
//
// Ports:
//   CLK       clock; all state changes on its rising edge
//   SRST      synchronous active-high reset; overrides every other input
//   Q_IN      latch output Q, asynchronous to CLK
//   ACK       consumer acknowledge for the pending report
//   DATA_OUT  last accepted value (registered)
//   VALID     a report is pending on DATA_OUT (registered)
//   CHG_CNT   number of accepted changes, saturating (registered)
//   OVERRUN   sticky: the input changed while a report was pending (registered)
module latch_q_sampler #(
    parameter int unsigned WIDTH         = 2,
    parameter int unsigned STABLE_CYCLES = 3,
    parameter int unsigned CNT_WIDTH     = 8
) (
    input  logic                 CLK,
    input  logic                 SRST,
    input  logic [WIDTH-1:0]     Q_IN,
    input  logic                 ACK,
    output logic [WIDTH-1:0]     DATA_OUT,
    output logic                 VALID,
    output logic [CNT_WIDTH-1:0] CHG_CNT,
    output logic                 OVERRUN
);

    localparam int unsigned           STAB_W    = 4;
    localparam logic [STAB_W-1:0]     STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        REPORT = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      s1_q, s1_d;
    logic [WIDTH-1:0]      s2_q, s2_d;
    logic [WIDTH-1:0]      cand_q, cand_d;
    logic [STAB_W-1:0]     stab_q, stab_d;
    logic [WIDTH-1:0]      data_out_q, data_out_d;
    logic                  valid_q, valid_d;
    logic [CNT_WIDTH-1:0]  chg_cnt_q, chg_cnt_d;
    logic                  overrun_q, overrun_d;

    // State register; reset wins over everything, including a coincident ACK.
    always_ff @(posedge CLK) begin
        if (SRST) begin
            state_q    <= IDLE;
            s1_q       <= '0;
            s2_q       <= '0;
            cand_q     <= '0;
            stab_q     <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            chg_cnt_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            cand_q     <= cand_d;
            stab_q     <= stab_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            chg_cnt_q  <= chg_cnt_d;
            overrun_q  <= overrun_d;
        end
    end

    // Synchronizer, qualification and handshake next-state logic.
    always_comb begin
        state_d    = state_q;
        s1_d       = Q_IN;
        s2_d       = s1_q;
        cand_d     = cand_q;
        stab_d     = stab_q;
        data_out_d = data_out_q;
        valid_d    = valid_q;
        chg_cnt_d  = chg_cnt_q;
        overrun_d  = overrun_q;

        case (state_q)
            IDLE: begin
                if (s2_q != data_out_q) begin
                    cand_d  = s2_q;
                    stab_d  = STAB_W'(1);
                    state_d = SETTLE;
                end
            end

            SETTLE: begin
                if (s2_q == data_out_q) begin
                    // Input returned to the reported value: glitch, drop it.
                    state_d = IDLE;
                end else if (s2_q != cand_q) begin
                    // Candidate moved: restart qualification on the new value.
                    cand_d = s2_q;
                    stab_d = STAB_W'(1);
                end else if (stab_q == STAB_LAST) begin
                    data_out_d = cand_q;
                    valid_d    = 1'b1;
                    if (chg_cnt_q != CNT_MAX) begin
                        chg_cnt_d = chg_cnt_q + CNT_WIDTH'(1);
                    end
                    state_d = REPORT;
                end else begin
                    stab_d = stab_q + STAB_W'(1);
                end
            end

            REPORT: begin
                if (ACK) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else if (s2_q != data_out_q) begin
                    overrun_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign DATA_OUT = data_out_q;
    assign VALID    = valid_q;
    assign CHG_CNT  = chg_cnt_q;
    assign OVERRUN  = overrun_q;

endmodule
